// File: rtl/inflight_buf.sv
// Outstanding-transaction buffer between an issuing stage and an sram-like bus.
// Requests are issued, answered and retired strictly in order through a DEPTH-entry ring.
module inflight_buf #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int RW    = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     req_valid,
    input  logic [DW-1:0]            req_payload,
    output logic                     req_ready,
    output logic                     bus_req,
    input  logic                     bus_addr_ok,
    input  logic                     bus_data_ok,
    input  logic [RW-1:0]            bus_rdata,
    output logic                     out_valid,
    output logic [DW-1:0]            out_payload,
    output logic [RW-1:0]            out_rdata,
    input  logic                     out_ready,
    input  logic                     cancel,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL = PW'(DEPTH);

    typedef enum logic [1:0] {
        E_FREE,
        E_ISSUED,
        E_DONE
    } ent_state_e;

    ent_state_e      st_q   [DEPTH];
    logic            disc_q [DEPTH];
    logic [DW-1:0]   pl_q   [DEPTH];
    logic [RW-1:0]   rd_q   [DEPTH];

    logic [AW-1:0]   head_q, tail_q, resp_q;
    logic [PW-1:0]   pend_q, pend_d;
    logic            en_q;
    logic            issue, resp, retire;

    always_comb begin
        // en_q keeps req_ready low until the first edge after reset release
        req_ready   = en_q && (pend_q != FULL);
        bus_req     = req_valid && req_ready && !cancel;
        issue       = bus_req && bus_addr_ok;
        resp        = bus_data_ok && (st_q[resp_q] == E_ISSUED);
        out_valid   = (st_q[head_q] == E_DONE) && !disc_q[head_q] && !cancel;
        retire      = (st_q[head_q] == E_DONE) && (disc_q[head_q] || (out_valid && out_ready));
        out_payload = out_valid ? pl_q[head_q] : '0;
        out_rdata   = out_valid ? rd_q[head_q] : '0;
        pend_d      = pend_q + {{AW{1'b0}}, issue} - {{AW{1'b0}}, retire};
    end

    assign pending = pend_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                st_q[i]   <= E_FREE;
                disc_q[i] <= 1'b0;
                pl_q[i]   <= '0;
                rd_q[i]   <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            resp_q <= '0;
            pend_q <= '0;
            en_q   <= 1'b0;
        end else begin
            en_q <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (cancel && (st_q[i] != E_FREE)) disc_q[i] <= 1'b1;
            end
            if (issue) begin
                st_q[tail_q]   <= E_ISSUED;
                disc_q[tail_q] <= 1'b0;
                pl_q[tail_q]   <= req_payload;
                tail_q         <= tail_q + AW'(1);
            end
            if (resp) begin
                rd_q[resp_q] <= bus_rdata;
                st_q[resp_q] <= E_DONE;
                resp_q       <= resp_q + AW'(1);
            end
            // Retire is applied last so it overrides the cancel discard on the leaving entry
            if (retire) begin
                st_q[head_q]   <= E_FREE;
                disc_q[head_q] <= 1'b0;
                head_q         <= head_q + AW'(1);
            end
            pend_q <= pend_d;
        end
    end

endmodule

// File: tb/tb_inflight_buf.sv
// Bench for inflight_buf: vector table, directed corner sequences and random traffic
// checked every cycle against an in-order queue model of the outstanding transactions.
module tb_inflight_buf;

    localparam int DW = 32, DEPTH = 4, RW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          req_valid, bus_addr_ok, bus_data_ok, out_ready, cancel;
    logic [DW-1:0] req_payload;
    logic [RW-1:0] bus_rdata;
    logic          req_ready, bus_req, out_valid;
    logic [DW-1:0] out_payload;
    logic [RW-1:0] out_rdata;
    logic [2:0]    pending;

    inflight_buf #(.DW(DW), .DEPTH(DEPTH), .RW(RW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_payload(req_payload), .req_ready(req_ready),
        .bus_req(bus_req), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .out_valid(out_valid), .out_payload(out_payload),
        .out_rdata(out_rdata), .out_ready(out_ready), .cancel(cancel), .pending(pending)
    );

    typedef struct {
        logic [31:0] pl;
        logic [31:0] rd;
        bit          done;
        bit          disc;
    } ent_t;

    ent_t mq[$];
    bit   m_en;

    int checks = 0;
    int errors = 0;
    int n_issue = 0;

    logic        s_rdy, s_breq, s_ov;
    logic [31:0] s_pl, s_rd;
    logic [2:0]  s_pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; compares outputs, then advances the model one clock.
    task automatic step(input logic rv, input logic [31:0] pl, input logic aok,
                        input logic dok, input logic [31:0] rd, input logic ordy,
                        input logic cn);
        logic e_rdy, e_breq, e_ov, ret;
        logic [31:0] e_pl, e_rd;
        int sz, idx;
        ent_t t;
        req_valid = rv; req_payload = pl; bus_addr_ok = aok;
        bus_data_ok = dok; bus_rdata = rd; out_ready = ordy; cancel = cn;
        #1;
        sz     = mq.size();
        e_rdy  = m_en && (sz < DEPTH);
        e_breq = rv && e_rdy && !cn;
        e_ov   = (sz > 0) && mq[0].done && !mq[0].disc && !cn;
        e_pl   = e_ov ? mq[0].pl : 32'h0;
        e_rd   = e_ov ? mq[0].rd : 32'h0;
        s_rdy = req_ready; s_breq = bus_req; s_ov = out_valid;
        s_pl = out_payload; s_rd = out_rdata; s_pend = pending;
        chk("req_ready", s_rdy, e_rdy);
        chk("bus_req", s_breq, e_breq);
        chk("out_valid", s_ov, e_ov);
        chk("out_payload", s_pl, e_pl);
        chk("out_rdata", s_rd, e_rd);
        chk("pending", s_pend, sz);
        if (s_breq && aok) n_issue++;
        @(posedge clk);
        if (resetn) begin
            ret = (sz > 0) && mq[0].done && (mq[0].disc || (e_ov && ordy));
            idx = -1;
            for (int i = 0; i < sz; i++)
                if (idx < 0 && !mq[i].done) idx = i;
            if (dok && idx >= 0) begin
                t = mq[idx]; t.rd = rd; t.done = 1'b1; t.disc = t.disc | cn; mq[idx] = t;
            end
            if (cn)
                for (int i = 0; i < sz; i++) begin
                    t = mq[i]; t.disc = 1'b1; mq[i] = t;
                end
            if (ret) void'(mq.pop_front());
            if (e_breq && aok) begin
                t.pl = pl; t.rd = 32'h0; t.done = 1'b0; t.disc = 1'b0;
                mq.push_back(t);
            end
            m_en = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        mq.delete();
        m_en = 1'b0;
        req_valid = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        out_ready = 1'b1; cancel = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pending", pending, 0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rel_req_ready", s_rdy, 0);
    endtask

    typedef struct {
        logic rv; logic [31:0] pl; logic aok; logic dok; logic [31:0] rd;
        logic ordy; logic cn;
        logic e_rdy; logic e_breq; logic e_ov; logic [31:0] e_pl; logic [31:0] e_rd;
        logic [2:0] e_pend;
    } vec_t;

    vec_t tbl[10];
    int   seen;
    logic [31:0] last_pl;

    initial begin
        tbl[0] = '{1, 32'h1c000000, 1, 0, 32'h0,        0, 0, 1, 1, 0, 32'h0,        32'h0,        0};
        tbl[1] = '{1, 32'h1c000004, 1, 0, 32'h0,        0, 0, 1, 1, 0, 32'h0,        32'h0,        1};
        tbl[2] = '{0, 32'h0,        0, 1, 32'hAAAA0001, 0, 0, 1, 0, 0, 32'h0,        32'h0,        2};
        tbl[3] = '{0, 32'h0,        0, 1, 32'hAAAA0002, 1, 0, 1, 0, 1, 32'h1c000000, 32'hAAAA0001, 2};
        tbl[4] = '{0, 32'h0,        0, 0, 32'h0,        1, 0, 1, 0, 1, 32'h1c000004, 32'hAAAA0002, 1};
        tbl[5] = '{0, 32'h0,        0, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0,        32'h0,        0};
        tbl[6] = '{1, 32'h12345678, 1, 0, 32'h0,        1, 1, 1, 0, 0, 32'h0,        32'h0,        0};
        tbl[7] = '{1, 32'h12345678, 0, 0, 32'h0,        1, 0, 1, 1, 0, 32'h0,        32'h0,        0};
        tbl[8] = '{0, 32'h0,        0, 1, 32'hDEADBEEF, 1, 0, 1, 0, 0, 32'h0,        32'h0,        0};
        tbl[9] = '{0, 32'h0,        0, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0,        32'h0,        0};

        resetn = 1'b0;
        req_valid = 0; req_payload = 0; bus_addr_ok = 0; bus_data_ok = 0;
        bus_rdata = 0; out_ready = 0; cancel = 0;
        @(negedge clk);
        do_reset();

        // Two back-to-back transactions plus idle / cancel / stray data_ok rows
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rv, tbl[i].pl, tbl[i].aok, tbl[i].dok, tbl[i].rd, tbl[i].ordy, tbl[i].cn);
            chk($sformatf("tbl%0d_ready", i), s_rdy, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_busreq", i), s_breq, tbl[i].e_breq);
            chk($sformatf("tbl%0d_ovalid", i), s_ov, tbl[i].e_ov);
            chk($sformatf("tbl%0d_opayload", i), s_pl, tbl[i].e_pl);
            chk($sformatf("tbl%0d_ordata", i), s_rd, tbl[i].e_rd);
            chk($sformatf("tbl%0d_pending", i), s_pend, tbl[i].e_pend);
        end

        // Full ring: ready drops, and returns only the cycle after a retire
        for (int i = 0; i < 4; i++) step(1, 32'h2000_0000 + i * 4, 1, 0, 0, 0, 0);
        step(1, 32'h2000_0010, 1, 0, 0, 0, 0);
        chk("full_pending", s_pend, 4);
        chk("full_ready", s_rdy, 0);
        chk("full_busreq", s_breq, 0);
        step(0, 0, 0, 1, 32'hBBBB0000, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("full_retire_ov", s_ov, 1);
        chk("full_retire_ready", s_rdy, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("full_after_ready", s_rdy, 1);
        chk("full_after_pending", s_pend, 3);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 32'hBBBB0001 + i, 1, 0);
        chk("full_drained", s_pend, 0);

        // Cancel with three in flight: only the post-cancel request is presented
        for (int i = 0; i < 3; i++) step(1, 32'h1c000040 + i * 4, 1, 0, 0, 1, 0);
        step(1, 32'h1c0000ff, 1, 0, 0, 1, 1);
        chk("cancel_busreq", s_breq, 0);
        step(1, 32'h1c000100, 1, 0, 0, 1, 0);
        seen = 0; last_pl = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, (i < 4), 32'hCCCC0000 + i, 1, 0);
            if (s_ov) begin seen++; last_pl = s_pl; end
        end
        chk("cancel_presented", seen, 1);
        chk("cancel_payload", last_pl, 32'h1c000100);
        chk("cancel_pending", s_pend, 0);

        // Held output under back-pressure, then cancel on the third cycle
        step(1, 32'h1c000200, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h5555AAAA, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("hold%0d_ov", i), s_ov, 1);
            chk($sformatf("hold%0d_pl", i), s_pl, 32'h1c000200);
            chk($sformatf("hold%0d_rd", i), s_rd, 32'h5555AAAA);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        chk("hold_cancel_ov", s_ov, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("hold_after_ov", s_ov, 0);
        chk("hold_after_pending", s_pend, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("hold_retired", s_pend, 0);

        // Reset with two issued entries; late data_ok must be ignored
        step(1, 32'h1c000300, 1, 0, 0, 1, 0);
        step(1, 32'h1c000304, 1, 0, 0, 1, 0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 32'hEEEE0000 + i, 1, 0);
            chk($sformatf("late%0d_ov", i), s_ov, 0);
            chk($sformatf("late%0d_pending", i), s_pend, 0);
        end

        // Random concurrent issue / response / retire traffic
        n_issue = 0;
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, $urandom, 1, 0);
        chk("rand_drained", s_pend, 0);
        checks++;
        if (n_issue < 12) begin
            errors++;
            $display("FAIL rand_wrap: got %0d issues expected at least 12", n_issue);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inflight_buf.md
INFLIGHT_BUF -- requirements
Module: inflight_buf

Interface
REQ-001 Parameter DW, default 32: payload width (request PC or tag) carried per outstanding transaction.
REQ-002 Parameter DEPTH, default 4, power of two from 2 to 16: maximum number of outstanding transactions.
REQ-003 Parameter RW, default 32: bus read-data width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 resetn  input  1  reset, asynchronous and active-low.
REQ-006 req_valid  input  1  upstream stage has a request to issue.
REQ-007 req_payload  input  DW  payload stored with the request.
REQ-008 req_ready  output  1  a free entry exists.
REQ-009 bus_req  output  1  sram-like request strobe.
REQ-010 bus_addr_ok  input  1  bus accepted the request this cycle.
REQ-011 bus_data_ok  input  1  bus returns data for the oldest issued request.
REQ-012 bus_rdata  input  RW  returned data.
REQ-013 out_valid  output  1  head entry holds deliverable data.
REQ-014 out_payload  output  DW  payload of the head entry.
REQ-015 out_rdata  output  RW  data of the head entry.
REQ-016 out_ready  input  1  downstream stage accepts the output.
REQ-017 cancel  input  1  flush from branch or exception; all in-flight work becomes discardable.
REQ-018 pending  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-019 Storage SHALL be a DEPTH-entry ring with head, issue-tail and response pointers, each wrapping modulo DEPTH; every entry holds payload, rdata, state (FREE/ISSUED/DONE) and a discard bit.
REQ-020 req_ready SHALL be 1 iff pending < DEPTH, decided from registered state only, so a same-cycle retire does not raise it.
REQ-021 bus_req SHALL be req_valid & req_ready & ~cancel.
REQ-022 On bus_req & bus_addr_ok, the tail entry SHALL become ISSUED with discard=0 and req_payload stored, and the tail SHALL advance.
REQ-023 On bus_data_ok, the oldest ISSUED entry SHALL capture bus_rdata, become DONE, and the response pointer SHALL advance; responses are in order.
REQ-024 bus_data_ok with no ISSUED entry SHALL be ignored with no state change.
REQ-025 out_valid SHALL be 1 iff the head entry is DONE, its discard bit is 0, and cancel is 0; out_payload and out_rdata SHALL come from the head entry and be driven to 0 when out_valid is 0.
REQ-026 Latency: data_ok in cycle N SHALL give out_valid in cycle N+1 at the earliest; there is no combinational bypass.
REQ-027 The head SHALL retire (become FREE, pointer advances) on out_valid & out_ready, or when the head is DONE with discard=1; at most one retire per cycle.
REQ-028 On cancel, every non-FREE entry SHALL have its discard bit set; ISSUED entries stay allocated until their data_ok arrives, then retire silently.
REQ-029 Cancel together with data_ok SHALL capture the data and mark the entry discard.
REQ-030 Issue, response and retire in the same cycle SHALL all take effect; pending SHALL update by (+issue) - (retire).
REQ-031 Held output: while out_valid=1 and out_ready=0, out_payload and out_rdata SHALL stay stable unless cancel asserts.

Reset
REQ-032 resetn low SHALL immediately clear all entries to FREE with discard 0, zero all pointers and pending, and drive req_ready=0, bus_req=0 and out_valid=0 until the first clock edge after release, at which point req_ready=1.
REQ-033 Reset asserted mid-transaction SHALL drop all outstanding entries; a late data_ok after release SHALL be ignored per REQ-024.

Verification (DEPTH=4, DW=32, RW=32)
REQ-034 Issue payloads 0x1c000000 and 0x1c000004 back-to-back with addr_ok=1, then data_ok with 0xAAAA0001 and 0xAAAA0002, out_ready=1 -> outputs appear in order, each one cycle after its data_ok; pending returns to 0.
REQ-035 Issue 4 requests with no data_ok -> pending=4, req_ready=0, bus_req=0; one data_ok plus out_ready=1 -> req_ready=1 the cycle after retire.
REQ-036 Three ISSUED entries, then cancel for one cycle, then issue 0x1c000100, then 4 data_ok -> the first three responses are never presented, and only 0x1c000100 appears at the output.
REQ-037 out_valid=1 with out_ready=0 for 5 cycles -> payload and rdata held stable; cancel on cycle 3 -> out_valid=0 next cycle and the entry is retired.
REQ-038 Assert resetn=0 with 2 entries ISSUED, release, then apply data_ok -> out_valid stays 0 and pending=0.
REQ-039 Run a simultaneous issue, data_ok and retire for 20 cycles with random out_ready -> pending always in 0..4, no lost or duplicated payload, and wrap-around verified across at least 3 ring passes.
